// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl: frame sequencer for a shared-bus pixel array.
// Runs erase/expose/convert phases, drives a digital ramp during conversion,
// then reads each row over a valid/ready stream.
// Optional build macro: PIXEL_CTRL_GRAY_RAMP_EN drives ramp_data as Gray code.
module pixel_array_ctrl #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CNT_W-1:0]              c_erase,
  input  logic [CNT_W-1:0]              c_expose,
  input  logic [CNT_W-1:0]              c_convert,
  output logic                          erase,
  output logic                          expose,
  output logic                          convert,
  output logic [CNT_W-1:0]              ramp_data,
  output logic [ROWS-1:0]               read_sel,
  input  logic [7:0]                    pix_data,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  output logic [$clog2(ROWS)-1:0]       out_row,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int unsigned RW = $clog2(ROWS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ERASE   = 3'd1;
  localparam logic [2:0] S_EXPOSE  = 3'd2;
  localparam logic [2:0] S_CONVERT = 3'd3;
  localparam logic [2:0] S_RD_SEL  = 3'd4;
  localparam logic [2:0] S_RD_WAIT = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] len_x, len_x_n;
  logic [CNT_W-1:0] len_c, len_c_n;
  logic [RW-1:0]    row, row_n;
  logic [CNT_W-1:0] ramp_bin, ramp_bin_n;

  logic             erase_n, expose_n, convert_n;
  logic [CNT_W-1:0] ramp_data_n;
  logic [ROWS-1:0]  read_sel_n;
  logic             out_valid_n;
  logic [7:0]       out_data_n;
  logic [RW-1:0]    out_row_n;
  logic             busy_n, frame_done_n;

  // Phase length minus one, treating a zero request as one cycle.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    len_x_n     = len_x;
    len_c_n     = len_c;
    row_n       = row;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_row_n   = out_row;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ERASE;
          cnt_n   = len_m1(c_erase);
          len_x_n = len_m1(c_expose);
          len_c_n = len_m1(c_convert);
          row_n   = '0;
        end
      end
      S_ERASE: begin
        if (cnt == '0) begin
          state_n = S_EXPOSE;
          cnt_n   = len_x;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_EXPOSE: begin
        if (cnt == '0) begin
          state_n = S_CONVERT;
          cnt_n   = len_c;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_CONVERT: begin
        if (cnt == '0) begin
          state_n = S_RD_SEL;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_RD_SEL: begin
        out_data_n  = pix_data;
        out_row_n   = row;
        out_valid_n = 1'b1;
        state_n     = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          if (row == RW'(ROWS - 1)) begin
            state_n = S_DONE;
          end else begin
            row_n   = row + RW'(1);
            state_n = S_RD_SEL;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Ramp restarts at zero on the first conversion cycle.
    ramp_bin_n = '0;
    if (state_n == S_CONVERT) begin
      ramp_bin_n = (state == S_CONVERT) ? ramp_bin + CNT_W'(1) : '0;
    end
`ifdef PIXEL_CTRL_GRAY_RAMP_EN
    ramp_data_n = ramp_bin_n ^ (ramp_bin_n >> 1);
`else
    ramp_data_n = ramp_bin_n;
`endif

    erase_n      = (state_n == S_ERASE);
    expose_n     = (state_n == S_EXPOSE);
    convert_n    = (state_n == S_CONVERT);
    read_sel_n   = (state_n == S_RD_SEL) ? (ROWS'(1) << row_n) : '0;
    busy_n       = (state_n != S_IDLE);
    frame_done_n = (state_n == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len_x      <= '0;
      len_c      <= '0;
      row        <= '0;
      ramp_bin   <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      ramp_data  <= '0;
      read_sel   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      len_x      <= len_x_n;
      len_c      <= len_c_n;
      row        <= row_n;
      ramp_bin   <= ramp_bin_n;
      erase      <= erase_n;
      expose     <= expose_n;
      convert    <= convert_n;
      ramp_data  <= ramp_data_n;
      read_sel   <= read_sel_n;
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      out_row    <= out_row_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb_pixel_array_ctrl: scoreboard bench for pixel_array_ctrl (ROWS=4, CNT_W=8).
// Honours PIXEL_CTRL_GRAY_RAMP_EN for the expected ramp encoding.
module tb_pixel_array_ctrl;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned RW    = $clog2(ROWS);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] c_erase, c_expose, c_convert;
  logic             erase, expose, convert;
  logic [CNT_W-1:0] ramp_data;
  logic [ROWS-1:0]  read_sel;
  logic [7:0]       pix_data;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [RW-1:0]    out_row;
  logic             out_ready;
  logic             busy, frame_done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [7:0]    data;
  } word_t;

  word_t sb_q[$];

  pixel_array_ctrl #(.ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .c_erase(c_erase), .c_expose(c_expose), .c_convert(c_convert),
    .erase(erase), .expose(expose), .convert(convert),
    .ramp_data(ramp_data), .read_sel(read_sel), .pix_data(pix_data),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_ramp(input int n);
    logic [CNT_W-1:0] b;
    b = CNT_W'(n);
`ifdef PIXEL_CTRL_GRAY_RAMP_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic int eff(input int c);
    return (c == 0) ? 1 : c;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({erase, expose, convert, ramp_data, read_sel, out_valid,
                out_data, out_row, busy, frame_done});
  endfunction

  // One frame: push expected words, start, then monitor until frame_done.
  task automatic run_frame(input int ce, input int cx, input int cc,
                           input bit stall, input logic [7:0] b);
    int ne, nx, nc, cyc, wc, multi, stray;
    bit done;
    word_t w;
    ne = 0; nx = 0; nc = 0; wc = 0; multi = 0; stray = 0; done = 0;
    for (int r = 0; r < ROWS; r++) begin
      w.row  = RW'(r);
      w.data = b + 8'(r);
      sb_q.push_back(w);
    end
    @(negedge clk);
    c_erase = CNT_W'(ce); c_expose = CNT_W'(cx); c_convert = CNT_W'(cc);
    start = 1'b1;
    out_ready = !stall;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 4000) begin
      if (32'(erase) + 32'(expose) + 32'(convert) > 1) multi++;
      if (erase) ne++;
      if (expose) nx++;
      if (convert) begin
        check("ramp", 64'(ramp_data), 64'(exp_ramp(nc)));
        nc++;
      end else if (ramp_data != '0) begin
        stray++;
      end
      pix_data = 8'hEE;
      if (sb_q.size() != 0) begin
        if (read_sel != '0) check("read_sel", 64'(read_sel), 64'(ROWS'(1) << sb_q[0].row));
        if (read_sel[sb_q[0].row]) pix_data = b + 8'(sb_q[0].row);
      end
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'(1), 64'(0));
          out_ready = 1'b1;
        end else begin
          check("out_data", 64'(out_data), 64'(sb_q[0].data));
          check("out_row", 64'(out_row), 64'(sb_q[0].row));
          out_ready = stall ? (wc == 3) : 1'b1;
          if (out_ready) begin
            void'(sb_q.pop_front());
            wc = 0;
          end else begin
            wc++;
          end
        end
      end else begin
        out_ready = !stall;
      end
      if (frame_done) begin
        done = 1;
      end else begin
        cyc++;
        @(negedge clk);
      end
    end
    check("frame_timeout", 64'(done), 64'(1));
    check("erase_len", 64'(ne), 64'(eff(ce)));
    check("expose_len", 64'(nx), 64'(eff(cx)));
    check("convert_len", 64'(nc), 64'(eff(cc)));
    check("latency", 64'(cyc),
          64'(eff(ce) + eff(cx) + eff(cc) + 2 * ROWS + 1 + (stall ? 3 * ROWS : 0)));
    check("one_hot_phase", 64'(multi), 64'(0));
    check("ramp_outside", 64'(stray), 64'(0));
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    check("done_pulse", 64'({frame_done, busy}), 64'(0));
    out_ready = 1'b1;
  endtask

  initial begin
    int n;
    bit hit;
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; pix_data = 8'h00;
    c_erase = '0; c_expose = '0; c_convert = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 64'(0));

    // reset wins over a simultaneous start
    start = 1'b1;
    @(negedge clk);
    check("reset_prio", 64'(busy), 64'(0));
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));

    run_frame(5, 10, 20, 1'b0, 8'h40);
    run_frame(2, 3, 6, 1'b1, 8'h10);
    run_frame(0, 0, 0, 1'b0, 8'h80);

    // reset in CONVERT once the ramp reads 7
    @(negedge clk);
    c_erase = 8'd2; c_expose = 8'd2; c_convert = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; hit = 0;
    while (!hit && n < 200) begin
      if (convert && ramp_data == 8'd7) hit = 1;
      else begin n++; @(negedge clk); end
    end
    check("ramp7_seen", 64'(hit), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset", all_outs(), 64'(0));
    reset = 1'b0;
    sb_q.delete();
    run_frame(1, 1, 1, 1'b0, 8'h20);

    // start held high: busy-time starts ignored, back-to-back restart
    @(negedge clk);
    c_erase = '0; c_expose = '0; c_convert = '0; start = 1'b1; pix_data = 8'h00;
    @(negedge clk);
    n = 1;
    while (!frame_done && n < 200) begin n++; @(negedge clk); end
    check("b2b_latency", 64'(n), 64'(3 + 2 * ROWS + 1));
    n = 0;
    @(negedge clk);
    n++;
    while (!erase && n < 20) begin n++; @(negedge clk); end
    check("b2b_restart", 64'(n), 64'(2));
    start = 1'b0;
    n = 0;
    while (!frame_done && n < 200) begin n++; @(negedge clk); end
    check("b2b_second_done", 64'(frame_done), 64'(1));
    @(negedge clk);
    check("b2b_idle", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
